// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 machine-mode control path: FSM states,
// next-PC select codes, mcause codes and the trap request bundle.
package msrv32_pkg;

    typedef enum logic [1:0] {
        ST_RESET       = 2'b00,
        ST_OPERATING   = 2'b01,
        ST_TRAP_TAKEN  = 2'b10,
        ST_TRAP_RETURN = 2'b11
    } state_t;

    localparam logic [1:0] PC_BOOT = 2'b00;
    localparam logic [1:0] PC_EPC  = 2'b01;
    localparam logic [1:0] PC_TRAP = 2'b10;
    localparam logic [1:0] PC_NEXT = 2'b11;

    localparam logic [3:0] CAUSE_M_EXT_INT      = 4'd11;
    localparam logic [3:0] CAUSE_M_SW_INT       = 4'd3;
    localparam logic [3:0] CAUSE_M_TIMER_INT    = 4'd7;
    localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ECALL_M        = 4'd11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;

    // Interrupt flags arrive already gated by mstatus.MIE and their enables.
    typedef struct packed {
        logic ext_irq;
        logic sw_irq;
        logic tmr_irq;
        logic instr_misalign;
        logic illegal;
        logic ebreak;
        logic load_misalign;
        logic store_misalign;
        logic ecall;
    } trap_req_t;

endpackage

// File: rtl/msrv32_trap_cause_encoder.sv
// Priority encoder from pending trap requests to an mcause code.
// Interrupts outrank exceptions.
module msrv32_trap_cause_encoder
    import msrv32_pkg::*;
(
    input  trap_req_t  req,
    output logic [3:0] cause,
    output logic       is_interrupt
);

    always_comb begin
        cause        = 4'd0;
        is_interrupt = 1'b0;
        if (req.ext_irq) begin
            cause        = CAUSE_M_EXT_INT;
            is_interrupt = 1'b1;
        end else if (req.sw_irq) begin
            cause        = CAUSE_M_SW_INT;
            is_interrupt = 1'b1;
        end else if (req.tmr_irq) begin
            cause        = CAUSE_M_TIMER_INT;
            is_interrupt = 1'b1;
        end else if (req.instr_misalign) begin
            cause = CAUSE_INSTR_MISALIGN;
        end else if (req.illegal) begin
            cause = CAUSE_ILLEGAL;
        end else if (req.ebreak) begin
            cause = CAUSE_BREAKPOINT;
        end else if (req.load_misalign) begin
            cause = CAUSE_LOAD_MISALIGN;
        end else if (req.store_misalign) begin
            cause = CAUSE_STORE_MISALIGN;
        end else if (req.ecall) begin
            cause = CAUSE_ECALL_M;
        end
    end

endmodule

// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return sequencer: decodes ECALL/EBREAK/MRET, accepts
// traps, drives next-PC select, pipeline flush and CSR update strobes.
module msrv32_machine_control
    import msrv32_pkg::*;
(
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       e_irq_in,
    input  logic       t_irq_in,
    input  logic       s_irq_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       trap_taken_out,
    output logic       set_cause_out,
    output logic       set_epc_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic       instret_inc_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out
);

    state_t     state, next_state;
    trap_req_t  req;
    logic       sys_priv, ecall, ebreak, mret;
    logic       exception, interrupt;
    logic [3:0] enc_cause;
    logic       enc_is_irq;

    // Privileged SYSTEM forms share funct3=0 and zero rs1/rd.
    assign sys_priv = (opcode_6_to_2_in == OPCODE_SYSTEM) && (funct3_in == 3'b000)
                   && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign ecall  = sys_priv && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00000);
    assign ebreak = sys_priv && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'b00001);
    assign mret   = sys_priv && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'b00010);

    assign req.ext_irq        = mie_in & e_irq_in & meie_in;
    assign req.sw_irq         = mie_in & s_irq_in & msie_in;
    assign req.tmr_irq        = mie_in & t_irq_in & mtie_in;
    assign req.instr_misalign = misaligned_instr_in;
    assign req.illegal        = illegal_instr_in;
    assign req.ebreak         = ebreak;
    assign req.load_misalign  = misaligned_load_in;
    assign req.store_misalign = misaligned_store_in;
    assign req.ecall          = ecall;

    assign interrupt = req.ext_irq | req.sw_irq | req.tmr_irq;
    assign exception = illegal_instr_in | misaligned_instr_in | misaligned_load_in
                     | misaligned_store_in | ecall | ebreak;

    // Combinational so the decoder can squash a store in the trapping cycle.
    assign trap_taken_out = (state == ST_OPERATING) && (exception || interrupt);

    msrv32_trap_cause_encoder u_cause_enc (
        .req          (req),
        .cause        (enc_cause),
        .is_interrupt (enc_is_irq)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state      <= ST_RESET;
            cause_out  <= 4'd0;
            i_or_e_out <= 1'b0;
        end else begin
            state <= next_state;
            if (trap_taken_out) begin
                cause_out  <= enc_cause;
                i_or_e_out <= enc_is_irq;
            end
        end
    end

    always_comb begin
        next_state      = state;
        pc_src_out      = PC_BOOT;
        flush_out       = 1'b1;
        set_cause_out   = 1'b0;
        set_epc_out     = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        instret_inc_out = 1'b0;
        unique case (state)
            ST_RESET: begin
                next_state = ST_OPERATING;
            end
            ST_OPERATING: begin
                pc_src_out      = PC_NEXT;
                flush_out       = 1'b0;
                instret_inc_out = !trap_taken_out;
                if (trap_taken_out)
                    next_state = ST_TRAP_TAKEN;
                else if (mret)
                    next_state = ST_TRAP_RETURN;
            end
            ST_TRAP_TAKEN: begin
                pc_src_out    = PC_TRAP;
                set_cause_out = 1'b1;
                set_epc_out   = 1'b1;
                mie_clear_out = 1'b1;
                next_state    = ST_OPERATING;
            end
            ST_TRAP_RETURN: begin
                pc_src_out  = PC_EPC;
                mie_set_out = 1'b1;
                next_state  = ST_OPERATING;
            end
            default: next_state = ST_RESET;
        endcase
    end

endmodule

// File: tb/tb_msrv32_machine_control.sv
// Directed scoreboard bench for msrv32_machine_control: each cycle's expected
// outputs are queued at drive time and compared at the falling edge.
module tb_msrv32_machine_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       illegal, mis_load, mis_store, mis_instr;
    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1, rs2, rd;
    logic       e_irq, t_irq, s_irq, mie, meie, mtie, msie;
    logic [1:0] pc_src;
    logic       flush, trap_taken, set_cause, set_epc, mie_clear, mie_set, instret_inc, i_or_e;
    logic [3:0] cause;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [1:0] pc;
        logic       flush, trap, sc, se, mc, ms, ir, ioe;
        logic [3:0] cause;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    msrv32_machine_control dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .illegal_instr_in     (illegal),
        .misaligned_load_in   (mis_load),
        .misaligned_store_in  (mis_store),
        .misaligned_instr_in  (mis_instr),
        .opcode_6_to_2_in     (opcode),
        .funct3_in            (funct3),
        .funct7_in            (funct7),
        .rs1_addr_in          (rs1),
        .rs2_addr_in          (rs2),
        .rd_addr_in           (rd),
        .e_irq_in             (e_irq),
        .t_irq_in             (t_irq),
        .s_irq_in             (s_irq),
        .mie_in               (mie),
        .meie_in              (meie),
        .mtie_in              (mtie),
        .msie_in              (msie),
        .pc_src_out           (pc_src),
        .flush_out            (flush),
        .trap_taken_out       (trap_taken),
        .set_cause_out        (set_cause),
        .set_epc_out          (set_epc),
        .mie_clear_out        (mie_clear),
        .mie_set_out          (mie_set),
        .instret_inc_out      (instret_inc),
        .i_or_e_out           (i_or_e),
        .cause_out            (cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // st: 0 RESET, 1 OPERATING, 2 TRAP_TAKEN, 3 TRAP_RETURN
    function automatic exp_t mk(input string tag, input int st, input logic trap,
                                input logic [3:0] c, input logic ioe);
        exp_t e;
        e.tag = tag; e.trap = 1'b0; e.sc = 1'b0; e.se = 1'b0; e.mc = 1'b0;
        e.ms = 1'b0; e.ir = 1'b0; e.cause = c; e.ioe = ioe;
        case (st)
            0: begin e.pc = 2'b00; e.flush = 1'b1; end
            1: begin e.pc = 2'b11; e.flush = 1'b0; e.trap = trap; e.ir = !trap; end
            2: begin e.pc = 2'b10; e.flush = 1'b1; e.sc = 1'b1; e.se = 1'b1; e.mc = 1'b1; end
            default: begin e.pc = 2'b01; e.flush = 1'b1; e.ms = 1'b1; end
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.tag, ".pc_src"},    32'(pc_src),      32'(e.pc));
            chk({e.tag, ".flush"},     32'(flush),       32'(e.flush));
            chk({e.tag, ".trap"},      32'(trap_taken),  32'(e.trap));
            chk({e.tag, ".set_cause"}, 32'(set_cause),   32'(e.sc));
            chk({e.tag, ".set_epc"},   32'(set_epc),     32'(e.se));
            chk({e.tag, ".mie_clr"},   32'(mie_clear),   32'(e.mc));
            chk({e.tag, ".mie_set"},   32'(mie_set),     32'(e.ms));
            chk({e.tag, ".instret"},   32'(instret_inc), 32'(e.ir));
            chk({e.tag, ".i_or_e"},    32'(i_or_e),      32'(e.ioe));
            chk({e.tag, ".cause"},     32'(cause),       32'(e.cause));
        end
    end

    task automatic idle();
        illegal = 0; mis_load = 0; mis_store = 0; mis_instr = 0;
        opcode = 5'b01100; funct3 = 0; funct7 = 0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
        e_irq = 0; t_irq = 0; s_irq = 0; mie = 0; meie = 0; mtie = 0; msie = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic sys(input logic [6:0] f7, input logic [4:0] r2);
        opcode = 5'b11100; funct3 = 3'b000; rs1 = 0; rd = 0; funct7 = f7; rs2 = r2;
    endtask

    initial begin
        idle();
        tick(); sb.push_back(mk("rst_hold", 0, 0, 0, 0));
        tick(); rst = 1'b0; sb.push_back(mk("cycle0", 0, 0, 0, 0));
        tick(); sb.push_back(mk("cycle1", 1, 0, 0, 0));

        tick(); sys(7'd0, 5'd0); sb.push_back(mk("ecall", 1, 1, 0, 0));
        tick(); sb.push_back(mk("ecall_tt", 2, 0, 11, 0));
        tick(); sb.push_back(mk("ecall_post", 1, 0, 11, 0));

        tick(); mis_store = 1; t_irq = 1; mie = 1; mtie = 1;
        sb.push_back(mk("st_tirq", 1, 1, 11, 0));
        tick(); sb.push_back(mk("st_tirq_tt", 2, 0, 7, 1));
        tick(); sb.push_back(mk("st_tirq_post", 1, 0, 7, 1));

        tick(); sys(7'b0011000, 5'd2); e_irq = 1; meie = 1; mie = 1;
        sb.push_back(mk("mret_eirq", 1, 1, 7, 1));
        tick(); sb.push_back(mk("mret_eirq_tt", 2, 0, 11, 1));
        tick(); sb.push_back(mk("mret_eirq_post", 1, 0, 11, 1));

        tick(); sys(7'b0011000, 5'd2); sb.push_back(mk("mret", 1, 0, 11, 1));
        tick(); sb.push_back(mk("mret_tr", 3, 0, 11, 1));
        tick(); sb.push_back(mk("mret_post", 1, 0, 11, 1));

        tick(); e_irq = 1; meie = 1; mie = 0; sb.push_back(mk("irq_masked", 1, 0, 11, 1));
        tick(); sys(7'd0, 5'd5); sb.push_back(mk("sys_nop", 1, 0, 11, 1));

        // Timer request raised during TRAP_TAKEN must be taken on the next operating cycle.
        tick(); illegal = 1; sb.push_back(mk("illegal", 1, 1, 11, 1));
        tick(); t_irq = 1; mie = 1; mtie = 1; sb.push_back(mk("illegal_tt", 2, 0, 2, 0));
        tick(); t_irq = 1; mie = 1; mtie = 1; sb.push_back(mk("late_tirq", 1, 1, 2, 0));
        tick(); sb.push_back(mk("late_tirq_tt", 2, 0, 7, 1));

        tick(); s_irq = 1; msie = 1; mie = 1; t_irq = 1; mtie = 1;
        sb.push_back(mk("sw_vs_tmr", 1, 1, 7, 1));
        tick(); sb.push_back(mk("sw_vs_tmr_tt", 2, 0, 3, 1));

        tick(); sys(7'd0, 5'd1); mis_load = 1; sb.push_back(mk("ebrk_ld", 1, 1, 3, 1));
        tick(); sb.push_back(mk("ebrk_ld_tt", 2, 0, 3, 0));
        tick(); mis_instr = 1; illegal = 1; sb.push_back(mk("misi_ill", 1, 1, 3, 0));
        tick(); sb.push_back(mk("misi_ill_tt", 2, 0, 0, 0));

        tick(); sys(7'd0, 5'd0); sb.push_back(mk("ecall2", 1, 1, 0, 0));
        tick(); sb.push_back(mk("ecall2_tt", 2, 0, 11, 0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midtrap_rst.pc_src", 32'(pc_src), 32'd0);
        chk("midtrap_rst.cause",  32'(cause),  32'd0);
        chk("midtrap_rst.flush",  32'(flush),  32'd1);
        tick(); rst = 1'b0; sb.push_back(mk("post_rst_c0", 0, 0, 0, 0));
        tick(); sb.push_back(mk("post_rst_c1", 1, 0, 0, 0));

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
